// File: rtl/interpreter_stream_tx_if.sv
// interpreter_stream_tx_if
// Byte stream from the CPU output channel to the external interpreter link.
//   byte_out   : current byte (IDLE_BYTE of the transmitter while byte_valid=0)
//   byte_valid : byte_out holds a valid byte
//   byte_ready : consumer accepts byte_out in this cycle
//   last_byte  : current byte is the final byte of its word (qualified by byte_valid)
// The master modport is the transmitter and the slave modport is the interpreter side.
interface interpreter_stream_tx_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       last_byte;

  modport master (
    output byte_out,
    output byte_valid,
    output last_byte,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    input  last_byte,
    output byte_ready
  );
endinterface

// File: rtl/interpreter_stream_tx.sv
// interpreter_stream_tx
// CPU-to-interpreter output channel for the RSA pipeline CPU.
// The block captures ReadData on COM-tagged memory reads into a word FIFO.
// It then sends each word as NBYTES bytes over a valid/ready byte stream.
// All state is updated on the rising edge of clk and reset is synchronous.
//
// Ports
//   clk        : system clock
//   reset      : synchronous, active-high; aborts the current word and flushes the FIFO
//   MemtoReg   : CPU memory-read writeback strobe
//   COM        : read is tagged for the interpreter channel
//   ReadData   : word to capture
//   tx         : byte stream to the interpreter (master side of the interface)
//   full       : FIFO holds DEPTH words
//   empty      : FIFO holds no words
//   level      : words in the FIFO, not counting the word being serialised
//   overflow   : sticky flag, set when a push was dropped
//   clear_ovf  : clears overflow; a simultaneous drop wins
module interpreter_stream_tx #(
  parameter int         DATA_W    = 32,
  parameter int         NBYTES    = 4,
  parameter int         DEPTH     = 8,
  parameter int         MSB_FIRST = 0,
  parameter int         EDGE_PUSH = 1,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemtoReg,
  input  logic                     COM,
  input  logic [DATA_W-1:0]        ReadData,
  interpreter_stream_tx_if.master  tx,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   fifo_mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       level_next;
  logic [DATA_W-1:0]   head;
  logic [DATA_W-1:0]   shift;
  logic [IW-1:0]       idx;
  logic [7:0]          byte_out_r;
  logic                byte_valid_r;
  logic                last_r;
  logic                p;
  logic                p_q;
  logic                push;
  logic                push_ok;
  logic                drop;
  logic                pop;

  // This function returns byte number i of the send order for word w.
  // MSB_FIRST reverses the order, so byte NBYTES-1 is sent first.
  function automatic logic [7:0] pick(input logic [DATA_W-1:0] w, input int i);
    logic [DATA_W-1:0] s;
    int                pos;
    pos = (MSB_FIRST != 0) ? (NBYTES - 1 - i) : i;
    s   = w >> (8 * pos);
    return s[7:0];
  endfunction

  assign tx.byte_out   = byte_out_r;
  assign tx.byte_valid = byte_valid_r;
  assign tx.last_byte  = last_r;

  // A held strobe produces one push in edge mode and one push per cycle in level mode.
  assign p    = MemtoReg & COM;
  assign push = (EDGE_PUSH != 0) ? (p & ~p_q) : p;

  always_ff @(posedge clk) begin
    if (reset) p_q <= 1'b0;
    else       p_q <= p;
  end

  // The FSM pops the head when it loads a word. It loads either from IDLE or
  // straight after the last byte of the previous word is accepted.
  // The head is read combinationally, so the loaded word comes from the same cycle.
  assign head = fifo_mem[rd_ptr];

  always_comb begin
    pop = 1'b0;
    if (state == IDLE) pop = !empty;
    else               pop = byte_valid_r && tx.byte_ready && last_r && !empty;
  end

  // A full FIFO can still take a push when a pop frees a slot in the same cycle.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    level_next = level;
    if (push_ok && !pop)      level_next = level + LW'(1);
    else if (!push_ok && pop) level_next = level - LW'(1);
  end

  // The storage array has no reset. Only the pointers and the count define
  // which entries are live, so a flush only needs to reset those.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= ReadData;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  // The status flags are registered from the next count, so they match level.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      empty <= (level_next == '0);
      full  <= (level_next == LW'(DEPTH));
    end
  end

  // Overflow is sticky. A drop in the same cycle as clear_ovf keeps it set,
  // so a lost word is never hidden.
  always_ff @(posedge clk) begin
    if (reset)          overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  // The serialiser FSM registers byte_out and last_byte for the next cycle.
  // They therefore stay stable whenever a valid byte is stalled.
  // After the final byte, the FSM loads the next word at once if one is waiting.
  // This keeps words back-to-back with no idle cycle between them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      byte_valid_r <= 1'b0;
      byte_out_r   <= IDLE_BYTE;
      last_r       <= 1'b0;
      idx          <= '0;
      shift        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shift        <= head;
            idx          <= '0;
            byte_out_r   <= pick(head, 0);
            last_r       <= (NBYTES == 1);
            byte_valid_r <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          if (tx.byte_ready) begin
            if (!last_r) begin
              idx        <= idx + IW'(1);
              byte_out_r <= pick(shift, int'(idx) + 1);
              last_r     <= ((int'(idx) + 1) == (NBYTES - 1));
            end else if (!empty) begin
              shift      <= head;
              idx        <= '0;
              byte_out_r <= pick(head, 0);
              last_r     <= (NBYTES == 1);
            end else begin
              byte_valid_r <= 1'b0;
              byte_out_r   <= IDLE_BYTE;
              last_r       <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: begin
          state        <= IDLE;
          byte_valid_r <= 1'b0;
          byte_out_r   <= IDLE_BYTE;
          last_r       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interpreter_stream_tx.sv
// tb_interpreter_stream_tx
// Directed bench for interpreter_stream_tx with DATA_W=32, NBYTES=4 and DEPTH=8.
// A second instance with MSB_FIRST=1 shares all the stimulus.
// It is checked only on the first word.
// Inputs are driven just after each falling edge.
// Outputs are sampled at the falling edge, after the previous rising edge has updated them.
module tb_interpreter_stream_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_to_reg;
  logic        com;
  logic        clear_ovf;
  logic        ready;
  logic [31:0] read_data;

  logic        full, empty, overflow;
  logic [3:0]  level;
  logic        full_m, empty_m, overflow_m;
  logic [3:0]  level_m;

  int errors = 0;
  int checks = 0;

  interpreter_stream_tx_if lsb_if ();
  interpreter_stream_tx_if msb_if ();

  assign lsb_if.byte_ready = ready;
  assign msb_if.byte_ready = ready;

  always #5 clk = ~clk;

  interpreter_stream_tx #(.MSB_FIRST(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemtoReg  (mem_to_reg),
    .COM       (com),
    .ReadData  (read_data),
    .tx        (lsb_if),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  interpreter_stream_tx #(.MSB_FIRST(1)) dut_msb (
    .clk       (clk),
    .reset     (reset),
    .MemtoReg  (mem_to_reg),
    .COM       (com),
    .ReadData  (read_data),
    .tx        (msb_if),
    .full      (full_m),
    .empty     (empty_m),
    .level     (level_m),
    .overflow  (overflow_m),
    .clear_ovf (clear_ovf)
  );

  // This task counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // This task drives a one-cycle tagged read and then one quiet cycle.
  // It must be entered at a falling edge and returns at a falling edge.
  task automatic applyStimulus(input logic [31:0] data);
    mem_to_reg = 1'b1;
    com        = 1'b1;
    read_data  = data;
    @(negedge clk);
    mem_to_reg = 1'b0;
    com        = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    logic [31:0] s;
    s = w >> (8 * k);
    return s[7:0];
  endfunction

  function automatic logic [31:0] word_n(input int i);
    return 32'hA0B0C0D0 + 32'(i) * 32'h01010101;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] w;
    int          beats;
    int          max_level;
    logic        any_valid;
    int          idx;
    int          cyc;
    int          r;
    logic [31:0] wa, wb, cur;

    reset      = 1'b1;
    mem_to_reg = 1'b0;
    com        = 1'b0;
    clear_ovf  = 1'b0;
    ready      = 1'b0;
    read_data  = '0;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rst_valid", lsb_if.byte_valid, 0);
    checkOutput("rst_byte", lsb_if.byte_out, 8'hFF);
    checkOutput("rst_last", lsb_if.last_byte, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_ovf", overflow, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single word with latency N+2, both byte orders and IDLE_BYTE afterwards
    w          = 32'hA1B2C3D4;
    ready      = 1'b1;
    mem_to_reg = 1'b1;
    com        = 1'b1;
    read_data  = w;
    @(negedge clk);
    mem_to_reg = 1'b0;
    com        = 1'b0;
    checkOutput("lat_n1_valid", lsb_if.byte_valid, 0);
    checkOutput("lat_n1_level", level, 1);
    checkOutput("lat_n1_empty", empty, 0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checkOutput("lsb_valid", lsb_if.byte_valid, 1);
      checkOutput("lsb_byte", lsb_if.byte_out, byte_of(w, k));
      checkOutput("lsb_last", lsb_if.last_byte, (k == 3));
      checkOutput("msb_byte", msb_if.byte_out, byte_of(w, 3 - k));
      checkOutput("msb_last", msb_if.last_byte, (k == 3));
      @(negedge clk);
    end
    checkOutput("post_valid", lsb_if.byte_valid, 0);
    checkOutput("post_byte", lsb_if.byte_out, 8'hFF);
    checkOutput("post_msb_byte", msb_if.byte_out, 8'hFF);

    // Held strobe produces a single push when edge detection is enabled
    beats      = 0;
    max_level  = 0;
    mem_to_reg = 1'b1;
    com        = 1'b1;
    read_data  = 32'h11223344;
    for (int i = 0; i < 12; i++) begin
      if (lsb_if.byte_valid) beats++;
      if (int'(level) > max_level) max_level = int'(level);
      if (i == 5) begin
        mem_to_reg = 1'b0;
        com        = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("edge_beats", beats, 4);
    checkOutput("edge_maxlvl", max_level, 1);

    // Untagged reads are never captured
    any_valid = 1'b0;
    com       = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_to_reg = (i % 2 == 0);
      any_valid  = any_valid | lsb_if.byte_valid;
      @(negedge clk);
    end
    mem_to_reg = 1'b0;
    checkOutput("com0_valid", any_valid, 0);
    checkOutput("com0_level", level, 0);
    checkOutput("com0_empty", empty, 1);

    // Fill to full while stalled, drop a tenth word, test overflow persistence and clear
    ready = 1'b0;
    for (int i = 1; i <= 9; i++) applyStimulus(word_n(i));
    checkOutput("fill_full", full, 1);
    checkOutput("fill_level", level, 8);
    checkOutput("fill_ovf", overflow, 0);
    checkOutput("fill_valid", lsb_if.byte_valid, 1);
    checkOutput("fill_byte", lsb_if.byte_out, byte_of(word_n(1), 0));
    applyStimulus(word_n(10));
    checkOutput("drop_ovf", overflow, 1);
    checkOutput("drop_level", level, 8);
    repeat (3) @(negedge clk);
    checkOutput("ovf_sticky", overflow, 1);
    mem_to_reg = 1'b1;
    com        = 1'b1;
    clear_ovf  = 1'b1;
    read_data  = word_n(11);
    @(negedge clk);
    mem_to_reg = 1'b0;
    com        = 1'b0;
    clear_ovf  = 1'b0;
    checkOutput("ovf_set_wins", overflow, 1);
    @(negedge clk);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    checkOutput("ovf_cleared", overflow, 0);
    checkOutput("ovf_level", level, 8);

    // Drain all nine stored words in order, back-to-back
    ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput("drain_valid", lsb_if.byte_valid, 1);
        checkOutput("drain_byte", lsb_if.byte_out, byte_of(word_n(i), k));
        checkOutput("drain_last", lsb_if.last_byte, (k == 3));
        @(negedge clk);
      end
    end
    checkOutput("drain_idle", lsb_if.byte_valid, 0);
    checkOutput("drain_empty", empty, 1);
    checkOutput("drain_level", level, 0);
    checkOutput("drain_full", full, 0);

    // Random stalls over two back-to-back words
    ready = 1'b0;
    wa    = 32'h5A6B7C8D;
    wb    = 32'h01234567;
    applyStimulus(wa);
    applyStimulus(wb);
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 200) begin
      cur = (idx < 4) ? wa : wb;
      checkOutput("hs_valid", lsb_if.byte_valid, 1);
      checkOutput("hs_byte", lsb_if.byte_out, byte_of(cur, idx % 4));
      checkOutput("hs_last", lsb_if.last_byte, (idx % 4 == 3));
      r     = int'($urandom_range(0, 1));
      ready = (r != 0);
      @(negedge clk);
      if (r != 0) idx++;
      cyc++;
    end
    checkOutput("hs_done", idx, 8);
    checkOutput("hs_idle", lsb_if.byte_valid, 0);

    // Reset after two of four bytes flushes the current word and the buffered word
    ready = 1'b0;
    applyStimulus(32'hCAFEBABE);
    applyStimulus(32'hDEADBEEF);
    ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mid_byte2", lsb_if.byte_out, 8'hFE);
    reset = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_rst_valid", lsb_if.byte_valid, 0);
    checkOutput("mid_rst_empty", empty, 1);
    checkOutput("mid_rst_level", level, 0);
    checkOutput("mid_rst_byte", lsb_if.byte_out, 8'hFF);
    repeat (3) @(negedge clk);
    checkOutput("mid_flushed", lsb_if.byte_valid, 0);
    ready = 1'b1;
    applyStimulus(32'h0F1E2D3C);
    checkOutput("restart_valid", lsb_if.byte_valid, 1);
    checkOutput("restart_byte", lsb_if.byte_out, 8'h3C);
    checkOutput("restart_last", lsb_if.last_byte, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
